// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select and load-use stall detection for an in-order pipeline.
// Tracks DEPTH producer stages downstream of ID; slot 1 is EX, slot k is EX+k-1.
module fwd_hazard_unit #(
    parameter int AW        = 5,
    parameter int NSRC      = 2,
    parameter int DEPTH     = 2,
    parameter int LOAD_DIST = 2,
    parameter int SW        = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 issue_valid_i,
    input  logic [AW-1:0]        issue_rd_i,
    input  logic                 issue_regwrite_i,
    input  logic                 issue_memread_i,
    input  logic [NSRC*AW-1:0]   src_addr_i,
    input  logic [NSRC-1:0]      src_used_i,
    input  logic                 hold_i,
    input  logic                 flush_i,
    output logic                 stall_o,
    output logic [NSRC*SW-1:0]   fwd_sel_o,
    output logic [NSRC*SW-1:0]   ex_fwd_sel_o,
    output logic [15:0]          stall_cnt_o
);

    // Index k-1 of each slot vector holds slot k.
    logic [DEPTH-1:0]   vld_q, vld_d;
    logic [DEPTH-1:0]   rw_q, rw_d;
    logic [DEPTH-1:0]   mr_q, mr_d;
    logic [AW-1:0]      rd_q [DEPTH];
    logic [AW-1:0]      rd_d [DEPTH];
    logic [NSRC*SW-1:0] ex_sel_q, ex_sel_d;
    logic [15:0]        cnt_q, cnt_d;

    logic [NSRC*SW-1:0] fwd_sel_s;
    logic               stall_s;
    logic [SW-1:0]      sel_s;
    logic               load_hit_s;

    // Youngest-producer match per operand and load-use stall detection.
    always_comb begin
        fwd_sel_s  = {(NSRC*SW){1'b0}};
        stall_s    = 1'b0;
        sel_s      = {SW{1'b0}};
        load_hit_s = 1'b0;
        for (int j = 0; j < NSRC; j++) begin
            sel_s      = {SW{1'b0}};
            load_hit_s = 1'b0;
            // Scan oldest to youngest so the smallest matching slot wins.
            for (int k = DEPTH; k >= 1; k--) begin
                if (src_used_i[j] && vld_q[k-1] && rw_q[k-1] &&
                    (rd_q[k-1] == src_addr_i[j*AW +: AW]) &&
                    (rd_q[k-1] != {AW{1'b0}})) begin
                    sel_s      = SW'(k);
                    load_hit_s = mr_q[k-1] && (k < LOAD_DIST);
                end else begin
                    sel_s      = sel_s;
                    load_hit_s = load_hit_s;
                end
            end
            fwd_sel_s[j*SW +: SW] = sel_s;
            if (load_hit_s && issue_valid_i) begin
                stall_s = 1'b1;
            end else begin
                stall_s = stall_s;
            end
        end
    end

    // Next-state: hold freezes everything; otherwise shift and fill slot 1.
    always_comb begin
        vld_d    = vld_q;
        rw_d     = rw_q;
        mr_d     = mr_q;
        rd_d     = rd_q;
        ex_sel_d = ex_sel_q;
        cnt_d    = cnt_q;
        if (!hold_i) begin
            for (int k = 1; k < DEPTH; k++) begin
                vld_d[k] = vld_q[k-1];
                rw_d[k]  = rw_q[k-1];
                mr_d[k]  = mr_q[k-1];
                rd_d[k]  = rd_q[k-1];
            end
            if (flush_i || stall_s) begin
                vld_d[0] = 1'b0;
                rw_d[0]  = 1'b0;
                mr_d[0]  = 1'b0;
                rd_d[0]  = {AW{1'b0}};
                ex_sel_d = {(NSRC*SW){1'b0}};
            end else begin
                vld_d[0] = issue_valid_i;
                rw_d[0]  = issue_regwrite_i;
                mr_d[0]  = issue_memread_i;
                rd_d[0]  = issue_rd_i;
                ex_sel_d = fwd_sel_s;
            end
            // A flushed stall is only a bubble, not a counted stall cycle.
            if (stall_s && !flush_i && (cnt_q != 16'hFFFF)) begin
                cnt_d = cnt_q + 16'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_q    <= {DEPTH{1'b0}};
            rw_q     <= {DEPTH{1'b0}};
            mr_q     <= {DEPTH{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                rd_q[k] <= {AW{1'b0}};
            end
            ex_sel_q <= {(NSRC*SW){1'b0}};
            cnt_q    <= 16'h0000;
        end else begin
            vld_q    <= vld_d;
            rw_q     <= rw_d;
            mr_q     <= mr_d;
            rd_q     <= rd_d;
            ex_sel_q <= ex_sel_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stall_o      = stall_s;
    assign fwd_sel_o    = fwd_sel_s;
    assign ex_fwd_sel_o = ex_sel_q;
    assign stall_cnt_o  = cnt_q;

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- AW, 5, register-address width.
- NSRC, 2, source operands per instruction.
- DEPTH, 2, in-flight producer slots tracked downstream of ID; slot 1 is EX, slot k is EX+k-1.
- LOAD_DIST, 2, a load in slot k < LOAD_DIST forces a stall.
- SW, clog2(DEPTH+1), select width.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1, the single clock.
- rst_i, in, 1, asynchronous active-low reset.
- issue_valid_i, in, 1, ID holds a real instruction.
- issue_rd_i, in, AW, destination register of the ID instruction.
- issue_regwrite_i, in, 1, the ID instruction writes rd.
- issue_memread_i, in, 1, the ID instruction is a load.
- src_addr_i, in, NSRC*AW, source addresses; operand j occupies bits [j*AW +: AW].
- src_used_i, in, NSRC, operand j is actually read.
- hold_i, in, 1, external pipeline freeze.
- flush_i, in, 1, kill the ID instruction.
- stall_o, out, 1, load-use hazard; ID and IF hold.
- fwd_sel_o, out, NSRC*SW, combinational select for the ID instruction.
- ex_fwd_sel_o, out, NSRC*SW, registered select for the instruction now in EX.
- stall_cnt_o, out, 16, saturating count of stall cycles.

Function
REQ-003 The block SHALL keep DEPTH slots; each slot holds valid, rd, regwrite and memread.
REQ-004 Operand j SHALL match slot k only when all of the following hold: src_used_i[j]=1, slot valid=1, slot regwrite=1, slot rd equals src j, and rd is not 0.
REQ-005 fwd_sel_o[j] SHALL equal the smallest matching k, i.e. the youngest producer wins; it SHALL be 0 when no slot matches.
REQ-006 stall_o SHALL be 1 when any operand's youngest match is in slot k with k < LOAD_DIST and that slot's memread=1, and issue_valid_i=1; otherwise stall_o SHALL be 0. stall_o is combinational with zero latency.
REQ-007 Update priority per rising edge SHALL be: reset > hold_i > flush_i > stall_o > normal issue.
REQ-008 When hold_i=1, all slots, ex_fwd_sel_o and stall_cnt_o SHALL keep their values.
REQ-009 On any non-hold edge, slot k SHALL load slot k-1 for k >= 2, and the contents of slot DEPTH SHALL be discarded. A producer that leaves slot DEPTH is served by the register file's write-through.
REQ-010 On a normal issue, slot 1 SHALL load {issue_valid_i, issue_rd_i, issue_regwrite_i, issue_memread_i}, and ex_fwd_sel_o SHALL load fwd_sel_o.
REQ-011 On flush_i=1 or stall_o=1 (with hold_i=0), slot 1 SHALL load a bubble (all fields 0), and ex_fwd_sel_o SHALL load 0.
REQ-012 An ex_fwd_sel_o value k>0 SHALL mean the operand is taken from the stage k positions after EX (1=MEM, 2=WB); 0 SHALL mean the register or immediate path.
REQ-013 stall_cnt_o SHALL increment by 1 on each edge where stall_o=1, hold_i=0 and flush_i=0, and SHALL saturate at 16'hFFFF.
REQ-014 When flush_i and stall_o are both 1, only a bubble SHALL be inserted, and the counter SHALL NOT increment.
REQ-015 With DEPTH=1, slot 1 SHALL be the only slot; all rules above SHALL still hold.

Reset
REQ-016 While rst_i=0, all slots SHALL be invalid (all fields 0), ex_fwd_sel_o SHALL be 0, and stall_cnt_o SHALL be 0, asynchronously and regardless of clk_i.
REQ-017 Deasserting rst_i in the middle of an operation SHALL leave no stale forwarding state; the first edge after release SHALL behave as a normal issue into empty slots.

Verification
REQ-018 The bench SHALL cover: issue add r3 (regwrite); next cycle ID reads src0=r3 -> fwd_sel_o[0]=1; one edge later ex_fwd_sel_o[0]=1.
REQ-019 The bench SHALL cover: issue lw r4; next cycle ID reads r4 -> stall_o=1 for exactly one cycle, stall_cnt_o=1; after that edge fwd_sel_o[0]=2 and stall_o=0.
REQ-020 The bench SHALL cover: r5 written in slot 1 and in slot 2 at the same time -> fwd_sel_o selects 1, the youngest producer.
REQ-021 The bench SHALL cover: producer with rd=0 and regwrite=1, consumer reads r0 -> fwd_sel_o=0 and stall_o=0.
REQ-022 The bench SHALL cover: hold_i=1 for 3 cycles during a load-use stall -> slots, ex_fwd_sel_o and stall_cnt_o unchanged; flush_i together with stall_o -> bubble inserted, counter unchanged.
REQ-023 The bench SHALL cover: preload stall_cnt_o to 16'hFFFE, then 3 stall cycles -> stall_cnt_o=16'hFFFF; drive rst_i=0 mid-clock -> all outputs 0 immediately.
